// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg: shared state encoding and widths for the skid pipe stage.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pipe_pkg;

  localparam int unsigned COUNT_W = 2;

  // Encodings equal the occupancy, so count is read straight off the state.
  typedef enum logic [COUNT_W-1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_dreg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_dreg: payload register with load enable and synchronous clear.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_dreg #(
  parameter int DATA_W = 71
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // Clear wins over load so a kill discards a same-cycle write.
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_skid_reg: two-entry skid buffer, registered valid/ready.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 71
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [COUNT_W-1:0] count
);

  state_e state_q;
  state_e state_d;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_main_load;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic [DATA_W-1:0] w_main_in;
  logic [DATA_W-1:0] w_skid_data;

  assign in_ready   = (state_q != FULL);
  assign out_valid  = (state_q != EMPTY);
  assign count      = state_q;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_comb begin
    state_d          = state_q;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (w_in_xfer) begin
          state_d     = HALF;
          w_main_load = 1'b1;
        end
      end
      HALF: begin
        if (w_in_xfer && !w_out_xfer) begin
          state_d     = FULL;
          w_skid_load = 1'b1;
        end else if (w_in_xfer && w_out_xfer) begin
          w_main_load = 1'b1;
        end else if (w_out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (w_out_xfer) begin
          state_d          = HALF;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign w_main_in = w_main_from_skid ? w_skid_data : in_data;

  pipe_dreg #(.DATA_W(DATA_W)) u_main (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (w_main_load),
    .d    (w_main_in),
    .q    (out_data)
  );

  pipe_dreg #(.DATA_W(DATA_W)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (w_skid_load),
    .d    (in_data),
    .q    (w_skid_data)
  );

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter: DATA_W, default 71, payload width (32 mo + 32 alu + 5 rn + wreg + m2reg); SHALL accept any value >= 1.
REQ-002 Port: clk  in  1  rising-edge clock; the single clock of the block.
REQ-003 Port: rst  in  1  synchronous reset, active-high.
REQ-004 Port: flush  in  1  synchronous kill of all held entries.
REQ-005 Port: in_valid  in  1  upstream payload valid.
REQ-006 Port: in_ready  out  1  block can accept a payload this cycle.
REQ-007 Port: in_data  in  DATA_W  upstream payload.
REQ-008 Port: out_valid  out  1  out_data holds a valid payload.
REQ-009 Port: out_ready  in  1  downstream accepts this cycle.
REQ-010 Port: out_data  out  DATA_W  oldest held payload.
REQ-011 Port: count  out  2  entries held (0..2).

Function
REQ-012 Input transfer (in_xfer) SHALL be in_valid & in_ready; output transfer (out_xfer) SHALL be out_valid & out_ready.
REQ-013 Storage SHALL be a main register (drives out_data) and a skid register; states EMPTY (count 0), HALF (1), FULL (2).
REQ-014 out_valid SHALL be (state != EMPTY); in_ready SHALL be (state != FULL).
REQ-015 in_ready and out_valid SHALL decode from state flops only: no combinational path from out_ready or in_valid to any output.
REQ-016 EMPTY: in_xfer -> HALF, main <= in_data.
REQ-017 HALF: in_xfer & !out_xfer -> FULL, skid <= in_data; in_xfer & out_xfer -> HALF, main <= in_data; !in_xfer & out_xfer -> EMPTY.
REQ-018 FULL: out_xfer -> HALF, main <= skid; no in_xfer possible.
REQ-019 Latency: payload accepted at edge N SHALL appear on out_data after edge N when the block was EMPTY, or HALF with out_xfer.
REQ-020 Throughput: with in_valid and out_ready held high, one transfer per cycle each side, no bubbles.
REQ-021 Ordering SHALL be strict FIFO; no payload duplicated or dropped except by flush/rst.
REQ-022 out_data SHALL stay stable while out_valid & !out_ready.
REQ-023 flush SHALL force EMPTY and zero main and skid at the next edge, overriding a simultaneous in_xfer (payload discarded) and out_xfer.
REQ-024 Transfer semantics of REQ-012 SHALL hold on a flush cycle: the upstream sees its payload accepted, the downstream sees its payload consumed.
REQ-025 Idle (no xfer, no flush): all state and data SHALL hold.

Reset
REQ-026 rst SHALL take priority over flush and all transfers.
REQ-027 While rst is high at an edge: state <= EMPTY, main and skid <= 0.
REQ-028 Post-reset outputs: out_valid 0, in_ready 1, count 0, out_data 0.
REQ-029 Reset asserted mid-operation SHALL discard all held entries at that edge.

Structure
REQ-030 Package pipe_pkg SHALL hold the state enum typedef (EMPTY/HALF/FULL) and the count width constant (2).
REQ-031 One sub-module, pipe_dreg: DATA_W-wide register with load enable and synchronous clear, instantiated twice (main, skid).
REQ-032 Target size 120-400 RTL lines; no memories, no second clock.

Verification
REQ-033 Reset: rst=1 for 2 cycles with in_valid=1 -> count 0, out_valid 0, in_ready 1, out_data 0.
REQ-034 Back-to-back: in_data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later each, count constant 1.
REQ-035 Backpressure: out_ready=0, push 0xA then 0xB -> count 2, in_ready 0, out_data 0xA stable; out_ready=1 -> 0xA then 0xB, then EMPTY.
REQ-036 Flush collision: FULL (0xA, 0xB), flush=1 with in_valid=1 (0xC), out_ready=1 -> next cycle count 0, 0xC never appears.
REQ-037 Reset over flush: HALF, rst=1 and flush=1 with in_xfer -> EMPTY, out_data 0.
REQ-038 Random: random in_valid/out_ready 10k cycles, DATA_W=1 and 71 -> scoreboard order exact, out_data stable under stall, count matches model.
